// File: rtl/i2s_rx_block_buffer.sv
// ----------------------------------------------------------------------------
// i2s_rx_block_buffer
//   Ping-pong block buffer placed after i2s_rx. Stereo frames are written into
//   one of two banks of BLOCK_SIZE frames. A filled bank is handed to the
//   processing stage, which reads it by frame address and then releases it.
//   The upstream stage is never back-pressured; a frame that arrives while the
//   write bank is still owned by the reader is dropped and flagged.
//
//   Bank ownership (one state per bank):
//     state      | meaning
//     BANK_EMPTY | owned by the writer, being filled or waiting to be filled
//     BANK_FULL  | owned by the reader, presented in fill order
//
// Ports:
//   clk, rst            block clock, asynchronous active-high reset
//   in_valid/in_l/in_r  one-cycle frame strobe with signed left/right samples
//   blk_ready, blk_sel  a full bank is presented; its index
//   rd_en, rd_addr      read request for a frame of the presented bank
//   rd_valid/rd_l/rd_r  read data, one cycle after rd_en
//   blk_done            reader releases the presented bank
//   overflow, ovf_clr   sticky dropped-frame flag and its clear
// ----------------------------------------------------------------------------
module i2s_rx_block_buffer #(
    parameter int SAMPLE_SIZE = 24,
    parameter int BLOCK_SIZE  = 64,
    parameter int PTR_BITS    = $clog2(BLOCK_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [SAMPLE_SIZE-1:0] in_l,
    input  logic [SAMPLE_SIZE-1:0] in_r,
    output logic                   blk_ready,
    output logic                   blk_sel,
    input  logic                   rd_en,
    input  logic [PTR_BITS-1:0]    rd_addr,
    output logic                   rd_valid,
    output logic [SAMPLE_SIZE-1:0] rd_l,
    output logic [SAMPLE_SIZE-1:0] rd_r,
    input  logic                   blk_done,
    output logic                   overflow,
    input  logic                   ovf_clr
);

    localparam int FRAME_W = 2 * SAMPLE_SIZE;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_t;

    bank_state_t bank_st     [2];
    bank_state_t bank_st_nxt [2];

    logic                wr_bank;
    logic [PTR_BITS-1:0] wr_ptr;
    logic                rd_bank;

    // Bank index is the address MSB, so bank b occupies words b*BLOCK_SIZE upward.
    logic [FRAME_W-1:0] mem [2*BLOCK_SIZE];

    logic wr_full;
    logic wr_accept;
    logic wr_drop;
    logic wr_last;
    logic bank_release;

    assign wr_full      = (bank_st[wr_bank] == BANK_FULL);
    assign wr_accept    = in_valid && !wr_full;
    assign wr_drop      = in_valid && wr_full;
    assign wr_last      = (wr_ptr == PTR_BITS'(BLOCK_SIZE - 1));
    assign blk_ready    = (bank_st[rd_bank] == BANK_FULL);
    assign blk_sel      = rd_bank;
    assign bank_release = blk_done && blk_ready;

    // Completion and release always target different banks: completion needs
    // the write bank EMPTY, release needs the read bank FULL.
    always_comb begin
        bank_st_nxt[0] = bank_st[0];
        bank_st_nxt[1] = bank_st[1];
        if (wr_accept && wr_last) begin
            bank_st_nxt[wr_bank] = BANK_FULL;
        end
        if (bank_release) begin
            bank_st_nxt[rd_bank] = BANK_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_st[0] <= BANK_EMPTY;
            bank_st[1] <= BANK_EMPTY;
        end else begin
            bank_st[0] <= bank_st_nxt[0];
            bank_st[1] <= bank_st_nxt[1];
        end
    end

    // Write pointer/bank; a drop leaves both untouched so writing resumes at
    // ptr 0 of the same bank once the reader gives it back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank  <= 1'b0;
            wr_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                if (wr_last) begin
                    wr_ptr  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_ptr <= wr_ptr + PTR_BITS'(1);
                end
            end
            if (wr_drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage without reset so it maps onto a dual-port RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[{wr_bank, wr_ptr}] <= {in_l, in_r};
        end
    end

    // A read in the release cycle still uses the old rd_bank, so it returns
    // data from the bank being released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bank  <= 1'b0;
            rd_valid <= 1'b0;
            rd_l     <= '0;
            rd_r     <= '0;
        end else begin
            rd_valid <= rd_en && blk_ready;
            if (rd_en && blk_ready) begin
                {rd_l, rd_r} <= mem[{rd_bank, rd_addr}];
            end
            if (bank_release) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_block_buffer.sv
module tb_i2s_rx_block_buffer;

    localparam int SS = 24;
    localparam int BS = 4;
    localparam int PB = 2;
    localparam int FW = 2 * SS;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [SS-1:0] in_l;
    logic [SS-1:0] in_r;
    logic          blk_ready;
    logic          blk_sel;
    logic          rd_en;
    logic [PB-1:0] rd_addr;
    logic          rd_valid;
    logic [SS-1:0] rd_l;
    logic [SS-1:0] rd_r;
    logic          blk_done;
    logic          overflow;
    logic          ovf_clr;

    i2s_rx_block_buffer #(
        .SAMPLE_SIZE(SS),
        .BLOCK_SIZE (BS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_l     (in_l),
        .in_r     (in_r),
        .blk_ready(blk_ready),
        .blk_sel  (blk_sel),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_l     (rd_l),
        .rd_r     (rd_r),
        .blk_done (blk_done),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a FIFO of completed blocks (at most two can be held),
    // plus the block currently being assembled.
    typedef struct packed {
        logic                  bank;
        logic [BS-1:0][FW-1:0] fr;
    } blk_t;

    blk_t                  full_q[$];
    logic [BS-1:0][FW-1:0] part;
    int                    part_cnt;
    logic                  part_bank;
    logic                  m_ovf;
    logic [FW-1:0]         sb[$];
    logic [FW-1:0]         last_exp;

    int checks;
    int errors;

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        full_q.delete();
        sb.delete();
        part      = '0;
        part_cnt  = 0;
        part_bank = 1'b0;
        m_ovf     = 1'b0;
        last_exp  = '0;
    endtask

    // One clock cycle of stimulus; the model is advanced from its pre-cycle
    // state, exactly as the hardware sees the inputs at the edge.
    task automatic step(input bit v, input logic [SS-1:0] l, input logic [SS-1:0] r,
                        input bit re, input int a, input bit d, input bit c);
        bit   ready;
        bit   drop;
        blk_t b;
        in_valid = v;
        in_l     = l;
        in_r     = r;
        rd_en    = re;
        rd_addr  = PB'(a);
        blk_done = d;
        ovf_clr  = c;
        ready = (full_q.size() > 0);
        drop  = v && (full_q.size() == 2);
        if (re && ready) sb.push_back(full_q[0].fr[a]);
        if (d && ready) b = full_q.pop_front();
        if (v && !drop) begin
            part[part_cnt] = {l, r};
            part_cnt++;
            if (part_cnt == BS) begin
                b.bank = part_bank;
                b.fr   = part;
                full_q.push_back(b);
                part_bank = ~part_bank;
                part_cnt  = 0;
            end
        end
        if (drop) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rd_en    = 1'b0;
        blk_done = 1'b0;
        ovf_clr  = 1'b0;
        check_val("blk_ready", 64'(blk_ready), 64'(full_q.size() > 0));
        check_val("blk_sel", 64'(blk_sel), 64'((full_q.size() > 0) ? full_q[0].bank : part_bank));
        check_val("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    task automatic frame(input int k);
        step(1'b1, SS'(k), SS'(-k), 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic rd(input int a);
        step(1'b0, '0, '0, 1'b1, a, 1'b0, 1'b0);
    endtask

    task automatic done();
        step(1'b0, '0, '0, 1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_clear();
        check_val("rst_blk_ready", 64'(blk_ready), 64'd0);
        check_val("rst_blk_sel", 64'(blk_sel), 64'd0);
        check_val("rst_rd_valid", 64'(rd_valid), 64'd0);
        check_val("rst_rd_l", 64'(rd_l), 64'd0);
        check_val("rst_rd_r", 64'(rd_r), 64'd0);
        check_val("rst_overflow", 64'(overflow), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rd_valid must match the oldest expected read; when idle,
    // the read data must hold the last expected value.
    initial begin
        logic [FW-1:0] exp;
        forever begin
            @(negedge clk);
            if (!rst) begin
                checks++;
                if (rd_valid) begin
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_rd_valid: got %h_%h with no read pending at %0t", rd_l, rd_r, $time);
                    end else begin
                        exp = sb.pop_front();
                        last_exp = exp;
                        if ({rd_l, rd_r} !== exp) begin
                            errors++;
                            $display("FAIL rd_data: got %h_%h expected %h at %0t", rd_l, rd_r, exp, $time);
                        end
                    end
                end else if ({rd_l, rd_r} !== last_exp) begin
                    errors++;
                    $display("FAIL rd_hold: got %h_%h expected %h at %0t", rd_l, rd_r, last_exp, $time);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_l     = '0;
        in_r     = '0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        blk_done = 1'b0;
        ovf_clr  = 1'b0;
        model_clear();
        do_reset();

        // Basic fill
        for (int k = 1; k <= 4; k++) frame(k);
        check_val("fill_ready", 64'(blk_ready), 64'd1);
        check_val("fill_sel", 64'(blk_sel), 64'd0);
        for (int a = 0; a < 4; a++) rd(a);
        done();

        // Ping-pong
        do_reset();
        for (int k = 1; k <= 8; k++) frame(k);
        check_val("pp_sel0", 64'(blk_sel), 64'd0);
        for (int a = 0; a < 4; a++) rd(a);
        done();
        check_val("pp_ready1", 64'(blk_ready), 64'd1);
        check_val("pp_sel1", 64'(blk_sel), 64'd1);
        for (int a = 0; a < 4; a++) rd(a);
        done();

        // Overflow, resume, clear, clear-vs-drop, drop-vs-release
        do_reset();
        for (int k = 1; k <= 9; k++) frame(k);
        check_val("ovf_set", 64'(overflow), 64'd1);
        done();
        frame(10);
        step(1'b0, '0, '0, 1'b0, 0, 1'b0, 1'b1);
        check_val("ovf_clr", 64'(overflow), 64'd0);
        for (int k = 11; k <= 13; k++) frame(k);
        step(1'b1, SS'(14), SS'(-14), 1'b0, 0, 1'b0, 1'b1);
        check_val("ovf_set_wins", 64'(overflow), 64'd1);
        step(1'b1, SS'(15), SS'(-15), 1'b1, 0, 1'b1, 1'b0);
        check_val("drop_release_sel", 64'(blk_sel), 64'd0);
        for (int a = 0; a < 4; a++) rd(a);
        done();
        for (int k = 16; k <= 19; k++) frame(k);
        rd(0);
        done();

        // Signed extremes, then reads/releases while nothing is presented
        do_reset();
        step(1'b1, 24'h800000, 24'h7FFFFF, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 24'h7FFFFF, 24'h800000, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 24'h000000, 24'hFFFFFF, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 24'h800001, 24'h000001, 1'b0, 0, 1'b0, 1'b0);
        for (int a = 3; a >= 0; a--) rd(a);
        done();
        step(1'b0, '0, '0, 1'b1, 2, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1, 1'b1, 1'b0);
        check_val("idle_ready", 64'(blk_ready), 64'd0);
        check_val("idle_sel", 64'(blk_sel), 64'd1);

        // Reset mid-block
        do_reset();
        for (int k = 1; k <= 6; k++) frame(k);
        check_val("mid_ready", 64'(blk_ready), 64'd1);
        do_reset();
        for (int k = 21; k <= 24; k++) frame(k);
        check_val("post_rst_sel", 64'(blk_sel), 64'd0);
        for (int a = 0; a < 4; a++) rd(a);
        done();

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 60, SS'($urandom), SS'($urandom),
                 $urandom_range(0, 99) < 50, int'($urandom_range(0, 3)),
                 $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 5);
        end

        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 0, 1'b0, 1'b0);
        check_val("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
